// File: rtl/educell_spike_ctrl.sv
// Per-cell spike sequencer for EDU syndrome matching.
// Each round works like this: a defect cell emits a spike, relay cells forward the
// first spike they see, and a defect or boundary cell ends the path. The arrival
// direction is latched one-hot for traceback, and a cycle budget bounds the round.
module educell_spike_ctrl #(
   parameter int MAX_CYCLES = 32,
   parameter int CNT_W      = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cfg_we,
   input  logic [5:0] cfg_mask,
   input  logic       cfg_boundary,
   input  logic       start,
   input  logic       flush,
   input  logic       syndrome_in,
   input  logic [5:0] spike_in,
   output logic       spike_out,
   output logic [5:0] syndir,
   output logic       matched,
   output logic       timeout,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE,
      EMIT,
      LISTEN,
      FIRE,
      RELAYED,
      DONE
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_CYCLES - 1);

   state_t           state;
   state_t           state_nxt;
   logic [5:0]       mask_q;
   logic             boundary_q;
   logic             defect_q;
   logic [CNT_W-1:0] cnt;
   logic [5:0]       eff;
   logic [5:0]       dir;
   logic             hit;
   logic             expire;
   logic             terminal;

   // Spikes only count while listening; a defect cell also blanks its own echo on the first LISTEN cycle
   always_comb begin
      eff = spike_in & mask_q;
      if ((state != LISTEN) || (defect_q && (cnt == '0))) begin
         eff = '0;
      end
   end

   // Fixed-priority one-hot encoder s > n > se > sw > ne > nw
   always_comb begin
      dir = '0;
      if (eff[0])      dir = 6'b000001;
      else if (eff[1]) dir = 6'b000010;
      else if (eff[2]) dir = 6'b000100;
      else if (eff[3]) dir = 6'b001000;
      else if (eff[4]) dir = 6'b010000;
      else if (eff[5]) dir = 6'b100000;
   end

   assign hit      = |eff;
   assign expire   = ((state == LISTEN) || (state == RELAYED)) && (cnt == LAST);
   assign terminal = defect_q | boundary_q;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; a spike on the expiry cycle wins over the timeout, and flush wins over everything
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (start) state_nxt = syndrome_in ? EMIT : LISTEN;
         EMIT:       state_nxt = LISTEN;
         LISTEN: begin
            if (hit)         state_nxt = terminal ? DONE : FIRE;
            else if (expire) state_nxt = DONE;
         end
         FIRE:       state_nxt = RELAYED;
         RELAYED:    if (expire) state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   // Output decode purely from state
   always_comb begin
      spike_out = (state == EMIT) || (state == FIRE);
      busy      = (state == EMIT) || (state == LISTEN) || (state == FIRE) || (state == RELAYED);
   end

   // Config, round counter and latched results. The counter saturates at the last budget
   // cycle, so a relay that fires on that cycle still sees expiry once it reaches RELAYED.
   always_ff @(posedge clk) begin
      if (rst) begin
         mask_q     <= 6'b111111;
         boundary_q <= 1'b0;
         defect_q   <= 1'b0;
         cnt        <= '0;
         syndir     <= '0;
         matched    <= 1'b0;
         timeout    <= 1'b0;
      end else if (flush) begin
         defect_q   <= 1'b0;
         cnt        <= '0;
         syndir     <= '0;
         matched    <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if ((state == IDLE) && cfg_we) begin
                  mask_q     <= cfg_mask;
                  boundary_q <= cfg_boundary;
               end
               if (start) begin
                  syndir   <= '0;
                  matched  <= 1'b0;
                  timeout  <= 1'b0;
                  cnt      <= '0;
                  defect_q <= syndrome_in;
               end
            end
            LISTEN: begin
               if (cnt != LAST) cnt <= cnt + 1'b1;
               if (hit) begin
                  syndir  <= dir;
                  matched <= terminal;
               end else if (expire) begin
                  timeout <= 1'b1;
               end
            end
            FIRE, RELAYED: begin
               if (cnt != LAST) cnt <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_educell_spike_ctrl.sv
// Self-checking bench for educell_spike_ctrl.
// Directed scenarios follow the intended round behaviour. A randomized section
// compares whole rounds against a closed-form round model.
module tb_educell_spike_ctrl;

   localparam int MAXC = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_we;
   logic [5:0] cfg_mask;
   logic       cfg_boundary;
   logic       start;
   logic       flush;
   logic       syndrome_in;
   logic [5:0] spike_in;
   logic       spike_out;
   logic [5:0] syndir;
   logic       matched;
   logic       timeout;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;

   // spike_in to drive at each cycle of a round; cycle 0 is the start cycle
   logic [5:0] stim [0:63];
   // bench-side copy of the configuration the DUT should hold
   logic [5:0] m_mask;
   logic       m_boundary;

   int         obs_spikes, obs_first_spike, obs_done;
   logic [5:0] obs_syndir;
   logic       obs_matched, obs_timeout;

   int         exp_spikes, exp_first_spike, exp_done;
   logic [5:0] exp_syndir;
   logic       exp_matched, exp_timeout;

   educell_spike_ctrl #(.MAX_CYCLES(MAXC), .CNT_W(6)) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_we       (cfg_we),
      .cfg_mask     (cfg_mask),
      .cfg_boundary (cfg_boundary),
      .start        (start),
      .flush        (flush),
      .syndrome_in  (syndrome_in),
      .spike_in     (spike_in),
      .spike_out    (spike_out),
      .syndir       (syndir),
      .matched      (matched),
      .timeout      (timeout),
      .busy         (busy)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Hard stop in case something wedges outside the bounded loops
   initial begin
      #500000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic clear_stim();
      for (int i = 0; i < 64; i++) stim[i] = '0;
   endtask

   // Return to IDLE with a flush, then load a new configuration
   task automatic load_cfg(input logic [5:0] m, input logic b);
      @(negedge clk); flush = 1'b1;
      @(negedge clk); flush = 1'b0; cfg_we = 1'b1; cfg_mask = m; cfg_boundary = b;
      @(negedge clk); cfg_we = 1'b0;
      m_mask = m;
      m_boundary = b;
   endtask

   // Drive one round from stim[] and record what the DUT did, sampled at negedges
   task automatic run_round(input logic defect);
      @(negedge clk); start = 1'b1; syndrome_in = defect; spike_in = '0;
      @(negedge clk); start = 1'b0; syndrome_in = 1'b0;
      obs_spikes = 0;
      obs_first_spike = -1;
      obs_done = -1;
      for (int c = 1; c < 60; c++) begin
         if (spike_out) begin
            obs_spikes++;
            if (obs_first_spike < 0) obs_first_spike = c;
         end
         if (!busy) begin
            obs_done = c;
            break;
         end
         spike_in = stim[c];
         @(negedge clk);
      end
      spike_in = '0;
      obs_syndir  = syndir;
      obs_matched = matched;
      obs_timeout = timeout;
   endtask

   // Round outcome from the rules: find the first usable spike within the budget, then
   // work out which outcome it produces and on which cycle the round ends
   task automatic model_round(input logic defect);
      int         l0, k;
      logic [5:0] e, hit_e;
      l0 = defect ? 2 : 1;
      k = -1;
      hit_e = '0;
      for (int j = 0; j < MAXC; j++) begin
         e = stim[l0 + j] & m_mask;
         if (defect && (j == 0)) e = '0;
         if (e != '0) begin
            k = j;
            hit_e = e;
            break;
         end
      end
      exp_spikes      = defect ? 1 : 0;
      exp_first_spike = defect ? 1 : -1;
      exp_syndir      = hit_e & (~hit_e + 6'd1);
      exp_matched     = 1'b0;
      exp_timeout     = 1'b0;
      if (k < 0) begin
         exp_timeout = 1'b1;
         exp_done    = l0 + MAXC;
      end else if (defect || m_boundary) begin
         exp_matched = 1'b1;
         exp_done    = l0 + k + 1;
      end else begin
         exp_spikes++;
         exp_first_spike = l0 + k + 1;
         exp_done = l0 + (((k + 2) > (MAXC - 1)) ? (k + 2) : (MAXC - 1)) + 1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (spike_out !== 1'b0) $display("[TB] FAIL reset.spike_out got=%b exp=0", spike_out); else n_pass++;
      n_checks++; if (syndir !== 6'b0) $display("[TB] FAIL reset.syndir got=%b exp=000000", syndir); else n_pass++;
      n_checks++; if (matched !== 1'b0) $display("[TB] FAIL reset.matched got=%b exp=0", matched); else n_pass++;
      n_checks++; if (timeout !== 1'b0) $display("[TB] FAIL reset.timeout got=%b exp=0", timeout); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset.busy got=%b exp=0", busy); else n_pass++;
   endtask

   // Defect cell: the echo on the first LISTEN cycle is ignored, and the se spike at cycle 4 matches
   task automatic test_defect_match();
      clear_stim();
      stim[2] = 6'b000001;
      stim[4] = 6'b000100;
      run_round(1'b1);
      n_checks++; if (obs_spikes !== 1) $display("[TB] FAIL defect.spike_count got=%0d exp=1", obs_spikes); else n_pass++;
      n_checks++; if (obs_first_spike !== 1) $display("[TB] FAIL defect.spike_cycle got=%0d exp=1", obs_first_spike); else n_pass++;
      n_checks++; if (obs_done !== 5) $display("[TB] FAIL defect.done_cycle got=%0d exp=5", obs_done); else n_pass++;
      n_checks++; if (obs_syndir !== 6'b000100) $display("[TB] FAIL defect.syndir got=%b exp=000100", obs_syndir); else n_pass++;
      n_checks++; if (obs_matched !== 1'b1) $display("[TB] FAIL defect.matched got=%b exp=1", obs_matched); else n_pass++;
   endtask

   // Relay cell: priority picks n out of 101010, fires one cycle later, and ignores later spikes
   task automatic test_relay();
      clear_stim();
      stim[3] = 6'b101010;
      stim[5] = 6'b000001;
      stim[6] = 6'b000001;
      run_round(1'b0);
      n_checks++; if (obs_syndir !== 6'b000010) $display("[TB] FAIL relay.syndir got=%b exp=000010", obs_syndir); else n_pass++;
      n_checks++; if (obs_first_spike !== 4) $display("[TB] FAIL relay.spike_cycle got=%0d exp=4", obs_first_spike); else n_pass++;
      n_checks++; if (obs_spikes !== 1) $display("[TB] FAIL relay.spike_count got=%0d exp=1", obs_spikes); else n_pass++;
      n_checks++; if (obs_matched !== 1'b0) $display("[TB] FAIL relay.matched got=%b exp=0", obs_matched); else n_pass++;
      n_checks++; if (obs_timeout !== 1'b0) $display("[TB] FAIL relay.timeout got=%b exp=0", obs_timeout); else n_pass++;
      n_checks++; if (obs_done !== 6) $display("[TB] FAIL relay.done_cycle got=%0d exp=6", obs_done); else n_pass++;
   endtask

   task automatic test_mask();
      load_cfg(6'b111110, 1'b0);
      clear_stim();
      stim[2] = 6'b000001;
      stim[3] = 6'b100000;
      run_round(1'b0);
      n_checks++; if (obs_syndir !== 6'b100000) $display("[TB] FAIL mask.syndir got=%b exp=100000", obs_syndir); else n_pass++;
      n_checks++; if (obs_first_spike !== 4) $display("[TB] FAIL mask.spike_cycle got=%0d exp=4", obs_first_spike); else n_pass++;
   endtask

   task automatic test_boundary();
      load_cfg(6'b111111, 1'b1);
      clear_stim();
      stim[2] = 6'b000001;
      run_round(1'b0);
      n_checks++; if (obs_matched !== 1'b1) $display("[TB] FAIL boundary.matched got=%b exp=1", obs_matched); else n_pass++;
      n_checks++; if (obs_syndir !== 6'b000001) $display("[TB] FAIL boundary.syndir got=%b exp=000001", obs_syndir); else n_pass++;
      n_checks++; if (obs_spikes !== 0) $display("[TB] FAIL boundary.spike_count got=%0d exp=0", obs_spikes); else n_pass++;
      n_checks++; if (obs_done !== 3) $display("[TB] FAIL boundary.done_cycle got=%0d exp=3", obs_done); else n_pass++;
   endtask

   task automatic test_timeout();
      load_cfg(6'b111111, 1'b0);
      clear_stim();
      run_round(1'b1);
      n_checks++; if (obs_timeout !== 1'b1) $display("[TB] FAIL timeout.defect_flag got=%b exp=1", obs_timeout); else n_pass++;
      n_checks++; if (obs_matched !== 1'b0) $display("[TB] FAIL timeout.defect_matched got=%b exp=0", obs_matched); else n_pass++;
      n_checks++; if (obs_done !== 6) $display("[TB] FAIL timeout.defect_done got=%0d exp=6", obs_done); else n_pass++;
      // a spike on the expiry cycle itself is still taken as a match
      clear_stim();
      stim[5] = 6'b001000;
      run_round(1'b1);
      n_checks++; if (obs_matched !== 1'b1) $display("[TB] FAIL timeout.edge_matched got=%b exp=1", obs_matched); else n_pass++;
      n_checks++; if (obs_timeout !== 1'b0) $display("[TB] FAIL timeout.edge_flag got=%b exp=0", obs_timeout); else n_pass++;
      n_checks++; if (obs_syndir !== 6'b001000) $display("[TB] FAIL timeout.edge_syndir got=%b exp=001000", obs_syndir); else n_pass++;
      // relay cell that never hears anything
      clear_stim();
      run_round(1'b0);
      n_checks++; if (obs_timeout !== 1'b1) $display("[TB] FAIL timeout.relay_flag got=%b exp=1", obs_timeout); else n_pass++;
      n_checks++; if (obs_done !== 5) $display("[TB] FAIL timeout.relay_done got=%0d exp=5", obs_done); else n_pass++;
   endtask

   task automatic test_flush();
      load_cfg(6'b111110, 1'b0);
      @(negedge clk); start = 1'b1; syndrome_in = 1'b0;
      @(negedge clk); start = 1'b0; spike_in = '0;
      @(negedge clk); spike_in = 6'b000010;
      @(negedge clk); spike_in = '0;
      n_checks++; if (spike_out !== 1'b1) $display("[TB] FAIL flush.fire_spike got=%b exp=1", spike_out); else n_pass++;
      flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      n_checks++; if (spike_out !== 1'b0) $display("[TB] FAIL flush.spike_out got=%b exp=0", spike_out); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("[TB] FAIL flush.busy got=%b exp=0", busy); else n_pass++;
      n_checks++; if (syndir !== 6'b0) $display("[TB] FAIL flush.syndir got=%b exp=000000", syndir); else n_pass++;
      // mask must survive the flush: an s-only spike is still filtered out
      clear_stim();
      stim[2] = 6'b000001;
      run_round(1'b0);
      n_checks++; if (obs_timeout !== 1'b1) $display("[TB] FAIL flush.mask_kept got=%b exp=1", obs_timeout); else n_pass++;
      // flush and start together: flush wins and the cell stays idle
      @(negedge clk); start = 1'b1; flush = 1'b1; syndrome_in = 1'b1;
      @(negedge clk); start = 1'b0; flush = 1'b0; syndrome_in = 1'b0;
      n_checks++; if (busy !== 1'b0) $display("[TB] FAIL flush.over_start_busy got=%b exp=0", busy); else n_pass++;
      n_checks++; if (timeout !== 1'b0) $display("[TB] FAIL flush.over_start_timeout got=%b exp=0", timeout); else n_pass++;
   endtask

   // A config write while in DONE must be dropped
   task automatic test_cfg_ignored();
      load_cfg(6'b111111, 1'b0);
      clear_stim();
      run_round(1'b0);
      @(negedge clk); cfg_we = 1'b1; cfg_mask = 6'b000000; cfg_boundary = 1'b1;
      @(negedge clk); cfg_we = 1'b0;
      clear_stim();
      stim[2] = 6'b000010;
      run_round(1'b0);
      n_checks++; if (obs_syndir !== 6'b000010) $display("[TB] FAIL cfg_ignored.syndir got=%b exp=000010", obs_syndir); else n_pass++;
      n_checks++; if (obs_spikes !== 1) $display("[TB] FAIL cfg_ignored.spike_count got=%0d exp=1", obs_spikes); else n_pass++;
   endtask

   task automatic test_rst_mid_round();
      load_cfg(6'b111110, 1'b1);
      @(negedge clk); start = 1'b1; syndrome_in = 1'b0;
      @(negedge clk); start = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      m_mask = 6'b111111;
      m_boundary = 1'b0;
      n_checks++; if (busy !== 1'b0) $display("[TB] FAIL rst_mid.busy got=%b exp=0", busy); else n_pass++;
      clear_stim();
      stim[2] = 6'b000001;
      run_round(1'b0);
      n_checks++; if (obs_syndir !== 6'b000001) $display("[TB] FAIL rst_mid.mask_restored got=%b exp=000001", obs_syndir); else n_pass++;
      n_checks++; if (obs_first_spike !== 3) $display("[TB] FAIL rst_mid.boundary_cleared got=%0d exp=3", obs_first_spike); else n_pass++;
   endtask

   task automatic test_random();
      logic       defect;
      logic [5:0] m;
      logic       b;
      for (int r = 0; r < 40; r++) begin
         m = 6'($urandom_range(1, 63));
         b = ($urandom_range(0, 3) == 0);
         load_cfg(m, b);
         defect = 1'($urandom_range(0, 1));
         clear_stim();
         for (int c = 1; c < 20; c++) begin
            if ($urandom_range(0, 3) == 0) stim[c] = 6'($urandom);
         end
         model_round(defect);
         run_round(defect);
         n_checks++; if (obs_done !== exp_done) $display("[TB] FAIL random[%0d].done got=%0d exp=%0d", r, obs_done, exp_done); else n_pass++;
         n_checks++; if (obs_spikes !== exp_spikes) $display("[TB] FAIL random[%0d].spike_count got=%0d exp=%0d", r, obs_spikes, exp_spikes); else n_pass++;
         n_checks++; if (obs_first_spike !== exp_first_spike) $display("[TB] FAIL random[%0d].spike_cycle got=%0d exp=%0d", r, obs_first_spike, exp_first_spike); else n_pass++;
         n_checks++; if (obs_syndir !== exp_syndir) $display("[TB] FAIL random[%0d].syndir got=%b exp=%b", r, obs_syndir, exp_syndir); else n_pass++;
         n_checks++; if (obs_matched !== exp_matched) $display("[TB] FAIL random[%0d].matched got=%b exp=%b", r, obs_matched, exp_matched); else n_pass++;
         n_checks++; if (obs_timeout !== exp_timeout) $display("[TB] FAIL random[%0d].timeout got=%b exp=%b", r, obs_timeout, exp_timeout); else n_pass++;
      end
   endtask

   // Run every scenario in order, then report
   initial begin
      rst = 1'b1;
      cfg_we = 1'b0;
      cfg_mask = '0;
      cfg_boundary = 1'b0;
      start = 1'b0;
      flush = 1'b0;
      syndrome_in = 1'b0;
      spike_in = '0;
      m_mask = 6'b111111;
      m_boundary = 1'b0;
      test_reset();
      test_defect_match();
      test_relay();
      test_mask();
      test_boundary();
      test_timeout();
      test_flush();
      test_cfg_ignored();
      test_rst_mid_round();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
